uart_rx_param: RTL and testbench
================================

# uart_rx_param

Parametrised UART receiver for the low-power communication system. It is the next-generation replacement for the fixed 8-bit receiver in the `Uart_Rx` slot. Data width is set at build time. Prescale, parity and stop-bit count are set at run time and latched per frame. It adds an input synchroniser, 3-sample majority voting, false-start rejection, 1/2 stop bits and break detection.

## Interface
Parameters:
- DATA_WIDTH, 8: data bits per frame; legal range 5..9.
- PRESCALE_WIDTH, 6: width of Prescale; maximum oversampling ratio is 2^PRESCALE_WIDTH-1.

Ports:
- CLK  in  1  single clock for the whole block.
- Reset  in  1  asynchronous, active-high reset.
- S_Data  in  1  serial line; idles high; asynchronous to CLK.
- Parity_EN  in  1  1 = a parity bit follows the data bits.
- Parity_type  in  1  0 = even parity, 1 = odd parity.
- Stop_bits  in  1  0 = one stop bit, 1 = two stop bits.
- Prescale  in  PRESCALE_WIDTH  CLK cycles per bit; legal range 5..max.
- P_Data  out  DATA_WIDTH  last received word, LSB first on the line; reset 0.
- Data_valid  out  1  one-cycle pulse for a clean frame; reset 0.
- Parity_error  out  1  result for the last frame; reset 0.
- stop_error  out  1  result for the last frame; reset 0.
- break_detect  out  1  one-cycle pulse on a break condition; reset 0.

## Operation
Input path:
- S_Data passes through a 2-flop synchroniser; both flops reset to 1.
- All logic below uses the synchronised signal (rx).

Bit timing:
- An edge counter runs 0..P-1 per bit, where P is the latched Prescale, and bit_count advances on each wrap.
- Samples are taken at edge counts h-1, h and h+1, where h = P>>1 (floor for odd P).
- The bit value is the majority of the three samples.
- The bit decision is registered on the cycle after edge count h+1 and is called "sampled".

States:
- IDLE: waits for rx = 0 (a falling edge relative to the previous cycle). On detection it latches Prescale, Parity_EN, Parity_type and Stop_bits, clears the counters, and goes to START.
- START: at sampled, a majority of 1 means a false start: return to IDLE with no flags or outputs changed. A majority of 0 goes to DATA.
- DATA: shifts DATA_WIDTH bits in, LSB first. After the last bit it goes to PARITY if Parity_EN is latched, otherwise to STOP.
- PARITY: compares the sampled bit with the XOR of the data bits (inverted for odd parity). Stores the mismatch.
- STOP: checks one or two stop bits; any sampled 0 marks a stop error. At the sampled point of the final stop bit, the frame completes.

Frame completion (same cycle for all of the following):
- P_Data loads the shift register, even on error.
- Parity_error and stop_error load this frame's result and hold until the next frame completes.
- Data_valid pulses only if both errors are 0.
- If all data bits, the parity bit (if enabled) and the stop bit(s) are all 0, break_detect pulses, stop_error is set, Data_valid stays 0, and the FSM enters WAIT_IDLE. Otherwise the FSM goes to IDLE.
- WAIT_IDLE: stays until rx = 1, then goes to IDLE.

Boundary conditions:
- Going back to IDLE at mid-stop-bit lets the next start bit be detected with up to half a bit of early arrival. Back-to-back frames lose no bits.
- Changes to Prescale or the mode inputs during a frame have no effect until the next start detect.
- A Prescale value below 5 is illegal and its behaviour is unspecified.
- Reset mid-frame returns the FSM to IDLE and returns all outputs and counters to their reset values immediately.

## Timing
- Pin to rx: 2 CLK cycles.
- The start falling edge on rx is detected in IDLE. The edge counter reads 0 on the following cycle.
- The bit k decision (k = 0 is the start bit) is registered at cycle k*P + h + 2 after the counter's first 0.
- Data_valid, P_Data, the error flags and break_detect update on the cycle after the final stop-bit decision.
- Data_valid and break_detect are never high for more than one cycle, and are never high in the same cycle.
- Frame length is 1 + DATA_WIDTH + Parity_EN + (1 + Stop_bits) bits.

## Test plan
- Clean frame: DATA_WIDTH=8, P=8, even parity, 1 stop, send 0xA5 with parity bit 0. Expect P_Data=0xA5, a 1-cycle Data_valid, and Parity_error=0, stop_error=0.
- Parity error: odd parity, send 0x3C with parity bit 0. Expect Parity_error=1, no Data_valid, P_Data=0x3C. A following clean 0x55 frame clears Parity_error and pulses Data_valid.
- False start / glitch: P=16, hold S_Data low for 3 cycles, then high. Expect no state change beyond START, no outputs, and a subsequent 0x81 received correctly.
- Two stop bits: Stop_bits=1, send 0xF0 with the second stop bit 0. Expect stop_error=1 and no Data_valid. Repeat with both stop bits 1: Data_valid, stop_error=0.
- Break: Parity_EN=1, hold S_Data low for 15 bit-times. Expect exactly one break_detect pulse and stop_error=1. No further frame is accepted until the line returns high; then 0x42 is received normally.
- Width, back-to-back and reset: DATA_WIDTH=9, P=5, three back-to-back frames 0x1FF, 0x000, 0x155. Expect three Data_valid pulses with matching P_Data. Assert Reset mid-fourth frame: all outputs go to 0 and the FSM returns to IDLE.

Source files
------------

// File: rtl/uart_rx_param_if.sv
// ---------------------------------------------------------------------------
// uart_rx_param_if
// Bundles the serial line, run-time configuration and frame results of the
// parametrised UART receiver.
//   master : the side that drives the line and configuration (transmitter /
//            system controller); it observes the receiver results.
//   slave  : the receiver itself.
// Signals:
//   S_Data       serial line, idles high, asynchronous to the receiver clock
//   Parity_EN    1 = a parity bit follows the data bits
//   Parity_type  0 = even, 1 = odd
//   Stop_bits    0 = one stop bit, 1 = two stop bits
//   Prescale     clock cycles per bit (legal 5..2^PRESCALE_WIDTH-1)
//   P_Data       last received word
//   Data_valid   one-cycle pulse for a clean frame
//   Parity_error parity result of the last completed frame
//   stop_error   stop-bit result of the last completed frame
//   break_detect one-cycle pulse on a break condition
// ---------------------------------------------------------------------------
interface uart_rx_param_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
);
    logic                      S_Data;
    logic                      Parity_EN;
    logic                      Parity_type;
    logic                      Stop_bits;
    logic [PRESCALE_WIDTH-1:0] Prescale;
    logic [DATA_WIDTH-1:0]     P_Data;
    logic                      Data_valid;
    logic                      Parity_error;
    logic                      stop_error;
    logic                      break_detect;

    modport master (
        output S_Data, Parity_EN, Parity_type, Stop_bits, Prescale,
        input  P_Data, Data_valid, Parity_error, stop_error, break_detect
    );

    modport slave (
        input  S_Data, Parity_EN, Parity_type, Stop_bits, Prescale,
        output P_Data, Data_valid, Parity_error, stop_error, break_detect
    );
endinterface

// File: rtl/uart_rx_param.sv
// ---------------------------------------------------------------------------
// uart_rx_param
// Parametrised UART receiver: 2-flop input synchroniser, 3-sample majority
// voting around mid-bit, false-start rejection, optional parity, one or two
// stop bits and break detection. Prescale and the mode inputs are latched at
// each start-bit detection.
// Ports:
//   CLK    single clock
//   Reset  asynchronous, active-high reset
//   bus    uart_rx_param_if.slave: line, configuration and frame results
// ---------------------------------------------------------------------------
module uart_rx_param #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input logic            CLK,
    input logic            Reset,
    uart_rx_param_if.slave bus
);
    localparam int BCW = 4;  // enough for the longest frame (13 bits)
    localparam logic [PRESCALE_WIDTH-1:0] PS_ONE    = PRESCALE_WIDTH'(1);
    localparam logic [BCW-1:0]            LAST_DATA = BCW'(DATA_WIDTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;

    state_t                    state_q, state_d;
    logic                      sync_q, sync_d, rx_q, rx_d, rx_prev_q, rx_prev_d;
    logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d, presc_q, presc_d;
    logic [BCW-1:0]            bit_cnt_q, bit_cnt_d;
    logic                      par_en_q, par_en_d, par_odd_q, par_odd_d, stop2_q, stop2_d;
    logic                      s0_q, s0_d, s1_q, s1_d, bit_q, bit_d, sampled_q, sampled_d;
    logic [DATA_WIDTH-1:0]     shreg_q, shreg_d, p_data_q, p_data_d;
    logic                      all_zero_q, all_zero_d, par_acc_q, par_acc_d, stop_acc_q, stop_acc_d;
    logic                      valid_q, valid_d, par_err_q, par_err_d, stop_err_q, stop_err_d;
    logic                      brk_q, brk_d;

    logic [PRESCALE_WIDTH-1:0] half;
    logic [BCW-1:0]            last_stop;
    logic                      start_edge, majority, stop_fail, all_zero, final_stop, go;

    always_comb begin
        // NOTE: every _d gets a default before any branch, so no path can infer a latch.
        sync_d     = bus.S_Data;
        rx_d       = sync_q;
        rx_prev_d  = rx_q;
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_cnt_d  = bit_cnt_q;
        presc_d    = presc_q;
        par_en_d   = par_en_q;
        par_odd_d  = par_odd_q;
        stop2_d    = stop2_q;
        s0_d       = s0_q;
        s1_d       = s1_q;
        bit_d      = bit_q;
        sampled_d  = 1'b0;
        shreg_d    = shreg_q;
        all_zero_d = all_zero_q;
        par_acc_d  = par_acc_q;
        stop_acc_d = stop_acc_q;
        p_data_d   = p_data_q;
        valid_d    = 1'b0;
        par_err_d  = par_err_q;
        stop_err_d = stop_err_q;
        brk_d      = 1'b0;
        go         = 1'b0;

        half       = presc_q >> 1;
        start_edge = rx_prev_q & ~rx_q;
        majority   = (s0_q & s1_q) | (s0_q & rx_q) | (s1_q & rx_q);
        stop_fail  = stop_acc_q | ~bit_q;
        all_zero   = all_zero_q & ~bit_q;
        // Bit index of the second stop bit (start bit is index 0).
        last_stop  = BCW'(DATA_WIDTH + 2) + {{(BCW-1){1'b0}}, par_en_q};
        final_stop = ~stop2_q | (bit_cnt_q == last_stop);

        // Bit timing: counter wraps every P cycles, samples straddle mid-bit.
        if (state_q != IDLE && state_q != WAIT_IDLE) begin
            if (cnt_q == presc_q - PS_ONE) begin
                cnt_d     = '0;
                bit_cnt_d = bit_cnt_q + BCW'(1);
            end else begin
                cnt_d = cnt_q + PS_ONE;
            end
            if (cnt_q == half - PS_ONE) s0_d = rx_q;
            if (cnt_q == half)          s1_d = rx_q;
            if (cnt_q == half + PS_ONE) begin
                bit_d     = majority;
                sampled_d = 1'b1;
            end
        end

        case (state_q)
            IDLE:  go = start_edge;
            START: if (sampled_q) state_d = bit_q ? IDLE : DATA;  // high majority = false start
            DATA: begin
                if (sampled_q) begin
                    shreg_d    = {bit_q, shreg_q[DATA_WIDTH-1:1]};  // LSB arrives first
                    all_zero_d = all_zero;
                    if (bit_cnt_q == LAST_DATA) state_d = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (sampled_q) begin
                    par_acc_d  = bit_q ^ (^shreg_q) ^ par_odd_q;
                    all_zero_d = all_zero;
                    state_d    = STOP;
                end
            end
            STOP: begin
                if (sampled_q) begin
                    if (final_stop) begin
                        p_data_d   = shreg_q;
                        par_err_d  = par_acc_q;
                        stop_err_d = stop_fail;  // an all-zero frame always has a failed stop bit
                        if (all_zero) begin
                            brk_d   = 1'b1;
                            state_d = WAIT_IDLE;
                        end else begin
                            valid_d = ~par_acc_q & ~stop_fail;
                            state_d = IDLE;
                            // At small prescales the next start edge can land on
                            // this very cycle; accept it here so no bit is lost.
                            go      = start_edge;
                        end
                    end else begin
                        stop_acc_d = stop_fail;
                        all_zero_d = all_zero;
                    end
                end
            end
            WAIT_IDLE: if (rx_q) state_d = IDLE;
            default:   state_d = IDLE;
        endcase

        if (go) begin
            state_d    = START;
            cnt_d      = '0;
            bit_cnt_d  = '0;
            presc_d    = bus.Prescale;
            par_en_d   = bus.Parity_EN;
            par_odd_d  = bus.Parity_type;
            stop2_d    = bus.Stop_bits;
            all_zero_d = 1'b1;
            par_acc_d  = 1'b0;
            stop_acc_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            // NOTE: the synchroniser and edge history reset to the idle line level
            // so a reset can never manufacture a falling edge.
            sync_q     <= 1'b1;
            rx_q       <= 1'b1;
            rx_prev_q  <= 1'b1;
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            presc_q    <= '0;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            stop2_q    <= 1'b0;
            s0_q       <= 1'b0;
            s1_q       <= 1'b0;
            bit_q      <= 1'b0;
            sampled_q  <= 1'b0;
            shreg_q    <= '0;
            all_zero_q <= 1'b0;
            par_acc_q  <= 1'b0;
            stop_acc_q <= 1'b0;
            p_data_q   <= '0;
            valid_q    <= 1'b0;
            par_err_q  <= 1'b0;
            stop_err_q <= 1'b0;
            brk_q      <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            rx_q       <= rx_d;
            rx_prev_q  <= rx_prev_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            presc_q    <= presc_d;
            par_en_q   <= par_en_d;
            par_odd_q  <= par_odd_d;
            stop2_q    <= stop2_d;
            s0_q       <= s0_d;
            s1_q       <= s1_d;
            bit_q      <= bit_d;
            sampled_q  <= sampled_d;
            shreg_q    <= shreg_d;
            all_zero_q <= all_zero_d;
            par_acc_q  <= par_acc_d;
            stop_acc_q <= stop_acc_d;
            p_data_q   <= p_data_d;
            valid_q    <= valid_d;
            par_err_q  <= par_err_d;
            stop_err_q <= stop_err_d;
            brk_q      <= brk_d;
        end
    end

    assign bus.P_Data       = p_data_q;
    assign bus.Data_valid   = valid_q;
    assign bus.Parity_error = par_err_q;
    assign bus.stop_error   = stop_err_q;
    assign bus.break_detect = brk_q;
endmodule

// File: tb/tb_uart_rx_param.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_param
// Directed bench for uart_rx_param: an 8-bit instance driven from a table of
// frames with hand-computed results, plus hand-written sequences for false
// start, break, a 9-bit back-to-back burst at P=5 and a mid-frame reset.
// ---------------------------------------------------------------------------
module tb_uart_rx_param;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_param_if #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) bus8 ();
    uart_rx_param_if #(.DATA_WIDTH(9), .PRESCALE_WIDTH(6)) bus9 ();

    uart_rx_param #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut8 (
        .CLK(clk), .Reset(rst), .bus(bus8.slave));
    uart_rx_param #(.DATA_WIDTH(9), .PRESCALE_WIDTH(6)) dut9 (
        .CLK(clk), .Reset(rst), .bus(bus9.slave));

    int n_vec = 0;
    int n_err = 0;
    int start_cyc = 0;

    // Output monitors (sampled on the falling edge)
    int         v8_cnt = 0, b8_cnt = 0, v8_cyc = 0;
    int         v9_cnt = 0, b9_cnt = 0, v9_cyc = 0;
    int         viol = 0;
    logic       dv8_prev = 1'b0, bk8_prev = 1'b0, dv9_prev = 1'b0, bk9_prev = 1'b0;
    logic [8:0] q9[$];

    always @(negedge clk) begin
        if (bus8.Data_valid) begin
            v8_cnt <= v8_cnt + 1;
            v8_cyc <= cyc;
        end
        if (bus8.break_detect) b8_cnt <= b8_cnt + 1;
        if (bus9.Data_valid) begin
            v9_cnt <= v9_cnt + 1;
            v9_cyc <= cyc;
            q9.push_back(bus9.P_Data);
        end
        if (bus9.break_detect) b9_cnt <= b9_cnt + 1;
        if ((bus8.Data_valid && dv8_prev) || (bus8.break_detect && bk8_prev) ||
            (bus8.Data_valid && bus8.break_detect) ||
            (bus9.Data_valid && dv9_prev) || (bus9.break_detect && bk9_prev) ||
            (bus9.Data_valid && bus9.break_detect))
            viol <= viol + 1;
        dv8_prev <= bus8.Data_valid;
        bk8_prev <= bus8.break_detect;
        dv9_prev <= bus9.Data_valid;
        bk9_prev <= bus9.break_detect;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_line(input bit sel, input logic v);
        if (sel) bus9.S_Data = v;
        else     bus8.S_Data = v;
    endtask

    // Hold the line at v for n cycles; always returns #1 after a rising edge.
    task automatic hold(input bit sel, input logic v, input int n);
        set_line(sel, v);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input bit sel, input logic pen, input logic podd,
                           input logic stop2, input int p);
        if (sel) begin
            bus9.Parity_EN = pen; bus9.Parity_type = podd;
            bus9.Stop_bits = stop2; bus9.Prescale = 6'(p);
        end else begin
            bus8.Parity_EN = pen; bus8.Parity_type = podd;
            bus8.Stop_bits = stop2; bus8.Prescale = 6'(p);
        end
    endtask

    // One frame, no leading or trailing idle. With scramble set, the 8-bit
    // instance's configuration inputs are disturbed after the start bit.
    task automatic send_frame(input bit sel, input logic [8:0] data, input int nbits,
                              input logic pen, input logic pbit, input int nstop,
                              input logic [1:0] stops, input int p, input bit scramble);
        start_cyc = cyc;
        hold(sel, 1'b0, p);
        if (scramble) set_cfg(1'b0, ~bus8.Parity_EN, ~bus8.Parity_type, ~bus8.Stop_bits, 37);
        for (int i = 0; i < nbits; i++) hold(sel, data[i], p);
        if (pen) hold(sel, pbit, p);
        hold(sel, stops[0], p);
        if (nstop == 2) hold(sel, stops[1], p);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       par_en;
        logic       par_odd;
        logic       stop2;
        logic       par_bit;
        logic [1:0] stops;      // [0] first stop bit, [1] second
        int         presc;
        int         exp_valid;
        logic [7:0] exp_pdata;
        logic       exp_perr;
        logic       exp_serr;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0, b0, k, lat;

        //             data   pen   podd  stp2  pbit  stops  P   val pdata  perr  serr
        vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 8,  1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 8,  0, 8'h3C, 1'b1, 1'b0};
        vecs[2] = '{8'h55, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 8,  1, 8'h55, 1'b0, 1'b0};
        vecs[3] = '{8'hF0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 8,  0, 8'hF0, 1'b0, 1'b1};
        vecs[4] = '{8'hF0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 8,  1, 8'hF0, 1'b0, 1'b0};
        vecs[5] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 13, 1, 8'h00, 1'b0, 1'b0};
        vecs[6] = '{8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 63, 1, 8'hFF, 1'b0, 1'b0};
        vecs[7] = '{8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 6,  0, 8'h01, 1'b0, 1'b1};

        rst = 1'b1;
        bus8.S_Data = 1'b1;
        bus9.S_Data = 1'b1;
        set_cfg(1'b0, 1'b0, 1'b0, 1'b0, 8);
        set_cfg(1'b1, 1'b0, 1'b0, 1'b0, 5);
        repeat (3) @(posedge clk);
        #1;
        check("reset P_Data",       32'(bus8.P_Data), 0);
        check("reset Data_valid",   32'(bus8.Data_valid), 0);
        check("reset Parity_error", 32'(bus8.Parity_error), 0);
        check("reset stop_error",   32'(bus8.stop_error), 0);
        check("reset break_detect", 32'(bus8.break_detect), 0);
        check("reset P_Data w9",    32'(bus9.P_Data), 0);
        rst = 1'b0;
        hold(1'b0, 1'b1, 4);

        // Table-driven frames on the 8-bit instance
        for (int i = 0; i < 8; i++) begin
            set_cfg(1'b0, vecs[i].par_en, vecs[i].par_odd, vecs[i].stop2, vecs[i].presc);
            hold(1'b0, 1'b1, 3 * vecs[i].presc);
            v0 = v8_cnt;
            b0 = b8_cnt;
            send_frame(1'b0, {1'b0, vecs[i].data}, 8, vecs[i].par_en, vecs[i].par_bit,
                       vecs[i].stop2 ? 2 : 1, vecs[i].stops, vecs[i].presc, 1'b1);
            hold(1'b0, 1'b1, 3 * vecs[i].presc);
            $display("vector %0d: data 0x%0h P=%0d", i, vecs[i].data, vecs[i].presc);
            check("valid pulses", 32'(v8_cnt - v0), 32'(vecs[i].exp_valid));
            check("P_Data",       32'(bus8.P_Data), 32'(vecs[i].exp_pdata));
            check("Parity_error", 32'(bus8.Parity_error), 32'(vecs[i].exp_perr));
            check("stop_error",   32'(bus8.stop_error), 32'(vecs[i].exp_serr));
            check("break pulses", 32'(b8_cnt - b0), 0);
            if (vecs[i].exp_valid == 1) begin
                // frame bits after the start bit, then pin->output latency
                k   = 8 + int'(vecs[i].par_en) + (vecs[i].stop2 ? 2 : 1);
                lat = k * vecs[i].presc + vecs[i].presc / 2 + 6;
                check("valid latency", 32'(v8_cyc - start_cyc), 32'(lat));
            end
        end

        // False start: 3-cycle glitch at P=16, then a real 0x81 frame
        set_cfg(1'b0, 1'b0, 1'b0, 1'b0, 16);
        hold(1'b0, 1'b1, 48);
        v0 = v8_cnt;
        b0 = b8_cnt;
        hold(1'b0, 1'b0, 3);
        hold(1'b0, 1'b1, 48);
        check("glitch valid pulses", 32'(v8_cnt - v0), 0);
        check("glitch break pulses", 32'(b8_cnt - b0), 0);
        check("glitch P_Data held",  32'(bus8.P_Data), 32'h01);
        check("glitch stop_error held", 32'(bus8.stop_error), 1);
        send_frame(1'b0, 9'h081, 8, 1'b0, 1'b0, 1, 2'b01, 16, 1'b0);
        hold(1'b0, 1'b1, 48);
        check("after glitch valid", 32'(v8_cnt - v0), 1);
        check("after glitch P_Data", 32'(bus8.P_Data), 32'h81);
        check("after glitch stop_error", 32'(bus8.stop_error), 0);
        check("after glitch latency", 32'(v8_cyc - start_cyc), 32'(9 * 16 + 8 + 6));

        // Break: 15 bit-times low with parity enabled, then 0x42
        set_cfg(1'b0, 1'b1, 1'b0, 1'b0, 8);
        hold(1'b0, 1'b1, 24);
        v0 = v8_cnt;
        b0 = b8_cnt;
        hold(1'b0, 1'b0, 15 * 8);
        check("break while low", 32'(b8_cnt - b0), 1);
        hold(1'b0, 1'b1, 40);
        check("break pulses", 32'(b8_cnt - b0), 1);
        check("break valid pulses", 32'(v8_cnt - v0), 0);
        check("break stop_error", 32'(bus8.stop_error), 1);
        check("break Parity_error", 32'(bus8.Parity_error), 0);
        check("break P_Data", 32'(bus8.P_Data), 0);
        send_frame(1'b0, 9'h042, 8, 1'b1, 1'b0, 1, 2'b01, 8, 1'b0);
        hold(1'b0, 1'b1, 24);
        check("after break valid", 32'(v8_cnt - v0), 1);
        check("after break P_Data", 32'(bus8.P_Data), 32'h42);
        check("after break stop_error", 32'(bus8.stop_error), 0);

        // 9-bit instance, P=5, three back-to-back frames
        hold(1'b1, 1'b1, 20);
        q9.delete();
        b0 = b9_cnt;
        send_frame(1'b1, 9'h1FF, 9, 1'b0, 1'b0, 1, 2'b01, 5, 1'b0);
        send_frame(1'b1, 9'h000, 9, 1'b0, 1'b0, 1, 2'b01, 5, 1'b0);
        send_frame(1'b1, 9'h155, 9, 1'b0, 1'b0, 1, 2'b01, 5, 1'b0);
        hold(1'b1, 1'b1, 20);
        check("b2b valid count", 32'(q9.size()), 3);
        if (q9.size() == 3) begin
            check("b2b frame0", 32'(q9[0]), 32'h1FF);
            check("b2b frame1", 32'(q9[1]), 32'h000);
            check("b2b frame2", 32'(q9[2]), 32'h155);
        end
        check("b2b break pulses", 32'(b9_cnt - b0), 0);
        check("b2b last latency", 32'(v9_cyc - start_cyc), 32'(10 * 5 + 2 + 6));
        check("b2b P_Data", 32'(bus9.P_Data), 32'h155);

        // Fourth frame cut short by an asynchronous reset
        hold(1'b1, 1'b0, 5);
        hold(1'b1, 1'b0, 5);
        hold(1'b1, 1'b1, 5);
        hold(1'b1, 1'b0, 5);
        #3 rst = 1'b1;
        #1;
        check("mid-frame reset P_Data w9",     32'(bus9.P_Data), 0);
        check("mid-frame reset Data_valid w9", 32'(bus9.Data_valid), 0);
        check("mid-frame reset stop_error w9", 32'(bus9.stop_error), 0);
        check("mid-frame reset P_Data w8",     32'(bus8.P_Data), 0);
        bus9.S_Data = 1'b1;
        bus8.S_Data = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        hold(1'b1, 1'b1, 10);
        q9.delete();
        send_frame(1'b1, 9'h0AA, 9, 1'b0, 1'b0, 1, 2'b01, 5, 1'b0);
        hold(1'b1, 1'b1, 20);
        check("post-reset valid count", 32'(q9.size()), 1);
        check("post-reset P_Data", 32'(bus9.P_Data), 32'h0AA);
        check("post-reset latency", 32'(v9_cyc - start_cyc), 32'(10 * 5 + 2 + 6));

        check("pulse width/overlap violations", 32'(viol), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
